// File: rtl/ad_sample_avg.sv
// ad_sample_avg: block averager for the dual-channel ADC interface.
// Synchronises the interface BUSY flag, takes one sample pair per BUSY fall,
// sums 2**LOG2_N pairs and emits truncated averages with a one-clock strobe.
module ad_sample_avg #(
    parameter int DW     = 8,
    parameter int LOG2_N = 3
) (
    input  logic          CLOCK_50MHz,
    input  logic          RESET_n,
    input  logic          ENABLE,
    input  logic          BUSY,
    input  logic [DW-1:0] DATA_AD0,
    input  logic [DW-1:0] DATA_AD1,
    output logic [DW-1:0] AVG_CH0,
    output logic [DW-1:0] AVG_CH1,
    output logic          AVG_VALID,
    output logic          OVERRUN
);

    localparam int AW = DW + LOG2_N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCUM,
        S_EMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              busy_q1;
    logic              busy_q2;
    logic              new_smp;
    logic [DW-1:0]     smp0;
    logic [DW-1:0]     smp1;
    logic [AW-1:0]     acc0;
    logic [AW-1:0]     acc1;
    logic [LOG2_N-1:0] cnt;
    logic              blk_last;

    logic              do_clear;
    logic              do_latch;
    logic              do_accum;
    logic              do_emit;
    logic              set_ovr;

    // Two-stage synchroniser for BUSY; resets high so an idle-high BUSY gives no false edge
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            busy_q1 <= 1'b1;
            busy_q2 <= 1'b1;
        end else begin
            busy_q1 <= BUSY;
            busy_q2 <= busy_q1;
        end
    end

    assign new_smp  = busy_q2 & ~busy_q1;
    assign blk_last = (cnt == '1);

    // State register
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; EMIT always completes before honouring ENABLE=0
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ENABLE) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!ENABLE)      state_nxt = S_IDLE;
                else if (new_smp) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (!ENABLE)       state_nxt = S_IDLE;
                else if (blk_last) state_nxt = S_EMIT;
                else               state_nxt = S_WAIT;
            end
            S_EMIT: begin
                state_nxt = ENABLE ? S_WAIT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state datapath controls; a sample arriving while one is in flight is flagged
    always_comb begin
        do_clear = 1'b0;
        do_latch = 1'b0;
        do_accum = 1'b0;
        do_emit  = 1'b0;
        set_ovr  = 1'b0;
        case (state)
            S_IDLE:  do_clear = 1'b1;
            S_WAIT:  do_latch = ENABLE & new_smp;
            S_ACCUM: begin
                do_accum = 1'b1;
                set_ovr  = new_smp;
            end
            S_EMIT: begin
                do_emit  = 1'b1;
                set_ovr  = new_smp;
            end
            default: do_clear = 1'b1;
        endcase
    end

    // Sample capture on each accepted BUSY fall
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            smp0 <= '0;
            smp1 <= '0;
        end else if (do_latch) begin
            smp0 <= DATA_AD0;
            smp1 <= DATA_AD1;
        end
    end

    // Accumulators and block counter; counter parks at its last value until EMIT clears it
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            acc0 <= '0;
            acc1 <= '0;
            cnt  <= '0;
        end else if (do_clear || do_emit) begin
            acc0 <= '0;
            acc1 <= '0;
            cnt  <= '0;
        end else if (do_accum) begin
            acc0 <= acc0 + AW'(smp0);
            acc1 <= acc1 + AW'(smp1);
            if (!blk_last) cnt <= cnt + LOG2_N'(1);
        end
    end

    // Average outputs and strobe; averages hold between strobes
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            AVG_CH0   <= '0;
            AVG_CH1   <= '0;
            AVG_VALID <= 1'b0;
        end else begin
            AVG_VALID <= do_emit;
            if (do_emit) begin
                AVG_CH0 <= acc0[AW-1:LOG2_N];
                AVG_CH1 <= acc1[AW-1:LOG2_N];
            end
        end
    end

    // Sticky overrun flag, cleared while idle
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            OVERRUN <= 1'b0;
        end else if (do_clear) begin
            OVERRUN <= 1'b0;
        end else if (set_ovr) begin
            OVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ad_sample_avg.sv
// tb_ad_sample_avg: directed bench for ad_sample_avg with a cycle-level
// reference model compared every clock, plus literal checks per scenario.
module tb_ad_sample_avg;

    localparam int DW = 8;
    localparam int L2 = 3;
    localparam int NS = 1 << L2;

    logic          CLOCK_50MHz;
    logic          RESET_n;
    logic          ENABLE;
    logic          BUSY;
    logic [DW-1:0] DATA_AD0;
    logic [DW-1:0] DATA_AD1;
    logic [DW-1:0] AVG_CH0;
    logic [DW-1:0] AVG_CH1;
    logic          AVG_VALID;
    logic          OVERRUN;

    int ntests = 0;
    int nfail  = 0;
    int nstrobe = 0;

    ad_sample_avg #(.DW(DW), .LOG2_N(L2)) dut (
        .CLOCK_50MHz (CLOCK_50MHz),
        .RESET_n     (RESET_n),
        .ENABLE      (ENABLE),
        .BUSY        (BUSY),
        .DATA_AD0    (DATA_AD0),
        .DATA_AD1    (DATA_AD1),
        .AVG_CH0     (AVG_CH0),
        .AVG_CH1     (AVG_CH1),
        .AVG_VALID   (AVG_VALID),
        .OVERRUN     (OVERRUN)
    );

    initial CLOCK_50MHz = 1'b0;
    always #10 CLOCK_50MHz = ~CLOCK_50MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A BUSY fall is seen as a sample in the cycle after the first
    // clock that samples it low. An accepted sample occupies the next cycle, and the
    // last of a block one more; a sample landing there is dropped and flags overrun.
    // The block average appears three cycles after the last sample's cycle.
    int            cyc;
    int            busy_until;
    int            strobe_cyc;
    int            m_cnt;
    int            m_s0, m_s1, m_p0, m_p1;
    logic          m_h1, m_h2, m_en_prev, m_pulse;
    logic          m_valid, m_ovr;
    logic [DW-1:0] m_avg0, m_avg1;

    always @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            cyc = 0; busy_until = -1; strobe_cyc = -1;
            m_cnt = 0; m_s0 = 0; m_s1 = 0; m_p0 = 0; m_p1 = 0;
            m_h1 = 1'b1; m_h2 = 1'b1; m_en_prev = 1'b0;
            m_valid = 1'b0; m_ovr = 1'b0; m_avg0 = '0; m_avg1 = '0;
        end else begin
            m_pulse = m_h2 && !m_h1;
            if (!m_en_prev) begin
                m_cnt = 0; m_s0 = 0; m_s1 = 0; m_ovr = 1'b0; busy_until = -1;
            end else if (m_pulse) begin
                if (cyc <= busy_until) begin
                    m_ovr = 1'b1;
                end else if (ENABLE) begin
                    m_s0 += int'(DATA_AD0);
                    m_s1 += int'(DATA_AD1);
                    m_cnt++;
                    if (m_cnt == NS) begin
                        m_p0 = m_s0 / NS;
                        m_p1 = m_s1 / NS;
                        strobe_cyc = cyc + 3;
                        busy_until = cyc + 2;
                        m_cnt = 0; m_s0 = 0; m_s1 = 0;
                    end else begin
                        busy_until = cyc + 1;
                    end
                end
            end
            m_en_prev = ENABLE;
            m_h2 = m_h1;
            m_h1 = BUSY;
            cyc++;
            m_valid = (cyc == strobe_cyc);
            if (m_valid) begin
                m_avg0 = m_p0[DW-1:0];
                m_avg1 = m_p1[DW-1:0];
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLOCK_50MHz) begin
        if (RESET_n) begin
            check("cyc_valid", 32'(AVG_VALID), 32'(m_valid));
            check("cyc_avg0",  32'(AVG_CH0),   32'(m_avg0));
            check("cyc_avg1",  32'(AVG_CH1),   32'(m_avg1));
            check("cyc_ovr",   32'(OVERRUN),   32'(m_ovr));
            if (AVG_VALID) nstrobe++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50MHz);
    endtask

    // Raise BUSY with new data, hold 20 clocks, then drop it (leaves BUSY low)
    task automatic fall(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge CLOCK_50MHz);
        BUSY = 1'b1;
        DATA_AD0 = d0;
        DATA_AD1 = d1;
        tick(20);
        BUSY = 1'b0;
    endtask

    task automatic sample(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        fall(d0, d1);
        tick(20);
    endtask

    // Count negedges until AVG_VALID is seen, bounded
    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            @(negedge CLOCK_50MHz);
            n++;
        end while (!AVG_VALID && n < 40);
        if (!AVG_VALID) begin
            nfail++;
            ntests++;
            $display("FAIL %s: no AVG_VALID within %0d clocks", name, n);
        end
    endtask

    int lat;
    int s0;

    initial begin
        RESET_n = 1'b0; ENABLE = 1'b0; BUSY = 1'b1; DATA_AD0 = '0; DATA_AD1 = '0;
        tick(3);
        // 1: reset values, BUSY activity while disabled
        check("rst_avg0",  32'(AVG_CH0),   32'h0);
        check("rst_avg1",  32'(AVG_CH1),   32'h0);
        check("rst_valid", 32'(AVG_VALID), 32'h0);
        check("rst_ovr",   32'(OVERRUN),   32'h0);
        RESET_n = 1'b1;
        for (int i = 0; i < 10; i++) sample(8'h11, 8'h22);
        check("idle_strobes", 32'(nstrobe), 32'd0);
        check("idle_ovr",     32'(OVERRUN), 32'h0);

        // 2: constant block, latency from last BUSY fall
        ENABLE = 1'b1;
        tick(5);
        for (int i = 0; i < NS - 1; i++) sample(8'h80, 8'h40);
        check("t2_no_early", 32'(nstrobe), 32'd0);
        fall(8'h80, 8'h40);
        wait_valid("t2_wait", lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_avg0", 32'(AVG_CH0), 32'h80);
        check("t2_avg1", 32'(AVG_CH1), 32'h40);
        tick(20);
        check("t2_strobes", 32'(nstrobe), 32'd1);

        // 3: ramp with truncation, full-scale channel without wrap
        for (int i = 0; i < NS - 1; i++) sample(DW'(i), 8'hFF);
        fall(8'h07, 8'hFF);
        wait_valid("t3_wait", lat);
        check("t3_avg0", 32'(AVG_CH0), 32'h03);
        check("t3_avg1", 32'(AVG_CH1), 32'hFF);
        tick(20);

        // 4: partial block discarded by ENABLE=0
        s0 = nstrobe;
        for (int i = 0; i < 5; i++) sample(8'hAA, 8'hAA);
        ENABLE = 1'b0;
        tick(10);
        ENABLE = 1'b1;
        for (int i = 0; i < NS - 1; i++) sample(8'h10, 8'h10);
        check("t4_no_partial", 32'(nstrobe - s0), 32'd0);
        fall(8'h10, 8'h10);
        wait_valid("t4_wait", lat);
        check("t4_avg0", 32'(AVG_CH0), 32'h10);
        check("t4_avg1", 32'(AVG_CH1), 32'h10);
        tick(20);

        // 5: asynchronous reset mid-block
        for (int i = 0; i < 4; i++) sample(8'h99, 8'h99);
        @(posedge CLOCK_50MHz);
        #3 RESET_n = 1'b0;
        BUSY = 1'b1;
        #1;
        check("t5_async_avg0",  32'(AVG_CH0),   32'h0);
        check("t5_async_avg1",  32'(AVG_CH1),   32'h0);
        check("t5_async_valid", 32'(AVG_VALID), 32'h0);
        tick(3);
        RESET_n = 1'b1;
        s0 = nstrobe;
        for (int i = 0; i < NS - 1; i++) sample(8'h33, 8'h44);
        check("t5_no_early", 32'(nstrobe - s0), 32'd0);
        fall(8'h33, 8'h44);
        wait_valid("t5_wait", lat);
        check("t5_avg0", 32'(AVG_CH0), 32'h33);
        check("t5_avg1", 32'(AVG_CH1), 32'h44);
        tick(20);

        // 6: long BUSY low counts once; a fall landing during EMIT is dropped
        s0 = nstrobe;
        fall(8'h20, 8'h20);
        tick(500);
        for (int i = 0; i < NS - 2; i++) sample(8'h20, 8'h20);
        check("t6_one_from_hold", 32'(nstrobe - s0), 32'd0);
        fall(8'h20, 8'h20);
        @(negedge CLOCK_50MHz);
        BUSY = 1'b1;
        @(negedge CLOCK_50MHz);
        BUSY = 1'b0;
        wait_valid("t6_wait", lat);
        check("t6_avg0", 32'(AVG_CH0), 32'h20);
        tick(5);
        check("t6_ovr_set", 32'(OVERRUN), 32'h1);
        tick(15);
        s0 = nstrobe;
        for (int i = 0; i < NS - 1; i++) sample(8'h08, 8'h08);
        check("t6_dropped", 32'(nstrobe - s0), 32'd0);
        fall(8'h08, 8'h08);
        wait_valid("t6_wait2", lat);
        check("t6_avg_next", 32'(AVG_CH0), 32'h08);
        check("t6_ovr_sticky", 32'(OVERRUN), 32'h1);
        tick(20);
        ENABLE = 1'b0;
        tick(5);
        check("t6_ovr_clear", 32'(OVERRUN), 32'h0);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
